// File: rtl/dadda_mac_pipe_64_pkg.sv
// Shared sizing constants for the Dadda multiply-accumulate pipeline.
package mac_pkg;
    localparam int WIDTH_DEF   = 64;
    localparam int ACC_W_DEF   = 136;
    localparam int GUARD_W_DEF = ACC_W_DEF - 2 * WIDTH_DEF;

    function automatic int guard_bits(input int width, input int acc_w);
        return acc_w - 2 * width;
    endfunction
endpackage

// File: rtl/dadda_mac_pipe_64_mult.sv
// Combinational unsigned multiplier: carry-save reduction of the partial-product
// array followed by a final ripple-carry adder.
module dadda_unsigned_multiplier_RCA_64 #(
    parameter int WIDTH = mac_pkg::WIDTH_DEF
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] p_o
);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] s, c, pp, t, sum;
    logic          cy;

    always_comb begin
        s   = '0;
        c   = '0;
        pp  = '0;
        t   = '0;
        sum = '0;
        cy  = 1'b0;
        // 3:2 compression keeps s + c equal to the running sum modulo 2^PW;
        // the true product fits in PW bits, so dropped MSB carries are harmless.
        for (int i = 0; i < WIDTH; i++) begin
            pp = b_i[i] ? (PW'(a_i) << i) : '0;
            t  = s ^ c ^ pp;
            c  = ((s & c) | (s & pp) | (c & pp)) << 1;
            s  = t;
        end
        for (int k = 0; k < PW; k++) begin
            sum[k] = s[k] ^ c[k] ^ cy;
            cy     = (s[k] & c[k]) | (cy & (s[k] ^ c[k]));
        end
        p_o = sum;
    end
endmodule

// File: rtl/dadda_mac_pipe_64.sv
// Three-stage multiply-accumulate: operand register, product register, then a
// group accumulator feeding a valid/ready result register.
module dadda_mac_pipe_64
    import mac_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0] a_q, b_q;
    logic             last1_q, v1_q;
    logic [PW-1:0]    p_q, prod;
    logic             last2_q, v2_q;
    logic [ACC_W-1:0] acc_q, out_acc_q, acc_d;
    logic             ovf_q, out_ovf_q, out_valid_q;
    logic [ACC_W:0]   sum_w;
    logic             carry, adv;

    dadda_unsigned_multiplier_RCA_64 #(.WIDTH(WIDTH)) u_mul (
        .a_i(a_q),
        .b_i(b_q),
        .p_o(prod)
    );

    // A full result register that the consumer is not taking freezes the whole pipe.
    assign adv      = !(out_valid_q && !out_ready);
    assign in_ready = adv && !clr;

    assign sum_w = {1'b0, acc_q} + {1'b0, ACC_W'(p_q)};
    assign carry = sum_w[ACC_W];
    assign acc_d = (SATURATE && carry) ? '1 : sum_w[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            last1_q     <= 1'b0;
            v1_q        <= 1'b0;
            p_q         <= '0;
            last2_q     <= 1'b0;
            v2_q        <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_acc_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            v1_q <= in_valid;
            if (in_valid) begin
                a_q     <= in_a;
                b_q     <= in_b;
                last1_q <= in_last;
            end
            v2_q    <= v1_q;
            p_q     <= prod;
            last2_q <= last1_q;
            if (v2_q && last2_q) begin
                out_acc_q   <= acc_d;
                out_ovf_q   <= ovf_q | carry;
                out_valid_q <= 1'b1;
                acc_q       <= '0;
                ovf_q       <= 1'b0;
            end else begin
                if (v2_q) begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_q | carry;
                end
                // adv with out_valid set implies out_ready, so this is the handshake.
                if (out_ready) out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_dadda_mac_pipe_64.sv
// Directed bench for dadda_mac_pipe_64: wrap and saturating instances share stimulus.
module tb_dadda_mac_pipe_64;
    localparam int W = 64;
    localparam int A = 136;

    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic in_ready, out_valid, out_ovf;
    logic [A-1:0] out_acc;
    logic s_in_ready, s_out_valid, s_out_ovf;
    logic [A-1:0] s_out_acc;

    int nchk = 0, npass = 0;
    logic [A-1:0] q_acc[$], qs_acc[$];
    logic         q_ovf[$], qs_ovf[$];

    always #5 clk = ~clk;

    dadda_mac_pipe_64 #(.WIDTH(W), .ACC_W(A), .SATURATE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf));

    dadda_mac_pipe_64 #(.WIDTH(W), .ACC_W(A), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_acc(s_out_acc), .out_ovf(s_out_ovf));

    // Record every completed handshake; inputs only change on negedge, so +1 is stable.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            q_acc.push_back(out_acc);
            q_ovf.push_back(out_ovf);
        end
        if (rst_n && s_out_valid && out_ready) begin
            qs_acc.push_back(s_out_acc);
            qs_ovf.push_back(s_out_ovf);
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic last,
                        output int stalls);
        stalls   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        #1;
        while (!in_ready && stalls < 50) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_n(input int n, input int budget, output bit ok);
        int c = 0;
        while (q_acc.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        #2;
        ok = (q_acc.size() >= n);
    endtask

    task automatic clear_q();
        q_acc.delete(); q_ovf.delete(); qs_acc.delete(); qs_ovf.delete();
    endtask

    task automatic test_reset();
        #3;
        nchk++;
        if (out_valid !== 1'b0 || out_acc !== '0 || out_ovf !== 1'b0)
            $display("FAIL reset_outputs: valid=%b acc=%0h ovf=%b required 0/0/0", out_valid, out_acc, out_ovf);
        else npass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nchk++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
        else npass++;
        @(negedge clk);
    endtask

    task automatic test_single();
        int st;
        clear_q();
        out_ready = 1'b1;
        send(64'd3, 64'd5, 1'b1, st);
        idle();
        #1;
        nchk++;
        if (out_valid !== 1'b0) $display("FAIL single_lat1: out_valid=%b required 0", out_valid);
        else npass++;
        @(negedge clk); #1;
        nchk++;
        if (out_valid !== 1'b0) $display("FAIL single_lat2: out_valid=%b required 0", out_valid);
        else npass++;
        @(negedge clk); #1;
        nchk++;
        if (out_valid !== 1'b1 || out_acc !== A'(15) || out_ovf !== 1'b0)
            $display("FAIL single_result: valid=%b acc=%0d ovf=%b required 1/15/0", out_valid, out_acc, out_ovf);
        else npass++;
        @(negedge clk); #1;
        nchk++;
        if (out_valid !== 1'b0) $display("FAIL single_drop: out_valid=%b required 0", out_valid);
        else npass++;
    endtask

    task automatic test_group4();
        int st, tot;
        bit ok;
        clear_q();
        tot = 0;
        send(64'd2, 64'd3, 1'b0, st); tot += st;
        send(64'd4, 64'd5, 1'b0, st); tot += st;
        send(64'd6, 64'd7, 1'b0, st); tot += st;
        send(64'd8, 64'd9, 1'b1, st); tot += st;
        idle();
        nchk++;
        if (tot !== 0) $display("FAIL group4_stalls: got %0d required 0", tot);
        else npass++;
        wait_n(1, 20, ok);
        nchk++;
        if (!ok || q_acc.size() != 1 || q_acc[0] !== A'(140) || q_ovf[0] !== 1'b0)
            $display("FAIL group4_result: n=%0d acc=%0d required n=1 acc=140 ovf=0",
                     q_acc.size(), ok ? q_acc[0] : '0);
        else npass++;
    endtask

    task automatic test_max(input int nmax, input logic [A-1:0] exp_wrap, input logic exp_ovf,
                            input logic [A-1:0] exp_sat);
        int st;
        bit ok;
        clear_q();
        for (int i = 0; i < nmax; i++) send('1, '1, 1'b0, st);
        send(64'd1, 64'd1, 1'b1, st);
        idle();
        wait_n(1, 20, ok);
        nchk++;
        if (!ok || q_acc[0] !== exp_wrap || q_ovf[0] !== exp_ovf)
            $display("FAIL max%0d_wrap: acc=%0h ovf=%b required acc=%0h ovf=%b",
                     nmax, ok ? q_acc[0] : '0, ok ? q_ovf[0] : 1'b0, exp_wrap, exp_ovf);
        else npass++;
        nchk++;
        if (qs_acc.size() != 1 || qs_acc[0] !== exp_sat || qs_ovf[0] !== exp_ovf)
            $display("FAIL max%0d_sat: n=%0d acc=%0h required acc=%0h ovf=%b",
                     nmax, qs_acc.size(), qs_acc.size() ? qs_acc[0] : '0, exp_sat, exp_ovf);
        else npass++;
    endtask

    task automatic test_backpressure();
        int st;
        bit ok;
        clear_q();
        out_ready = 1'b0;
        send(64'd1, 64'd1, 1'b1, st);
        send(64'd2, 64'd2, 1'b1, st);
        send(64'd3, 64'd3, 1'b1, st);
        idle();
        #1;
        nchk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== A'(1))
            $display("FAIL bp_stall: in_ready=%b valid=%b acc=%0d required 0/1/1", in_ready, out_valid, out_acc);
        else npass++;
        repeat (3) @(negedge clk);
        #1;
        nchk++;
        if (out_acc !== A'(1) || out_valid !== 1'b1 || q_acc.size() != 0)
            $display("FAIL bp_hold: acc=%0d valid=%b n=%0d required 1/1/0", out_acc, out_valid, q_acc.size());
        else npass++;
        out_ready = 1'b1;
        wait_n(3, 20, ok);
        nchk++;
        if (!ok || q_acc.size() != 3 || q_acc[0] !== A'(1) || q_acc[1] !== A'(4) || q_acc[2] !== A'(9))
            $display("FAIL bp_order: n=%0d required results 1,4,9 in order", q_acc.size());
        else npass++;
    endtask

    task automatic test_clr();
        int st;
        bit ok;
        clear_q();
        send(64'd10, 64'd10, 1'b0, st);
        send(64'd20, 64'd20, 1'b0, st);
        in_a = 64'd99; in_b = 64'd99; in_last = 1'b1; in_valid = 1'b1;
        clr = 1'b1;
        #1;
        nchk++;
        if (in_ready !== 1'b0) $display("FAIL clr_in_ready: got %b required 0", in_ready);
        else npass++;
        @(negedge clk);
        clr = 1'b0;
        idle();
        #1;
        nchk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL clr_after: in_ready=%b valid=%b required 1/0", in_ready, out_valid);
        else npass++;
        repeat (4) @(negedge clk);
        nchk++;
        if (q_acc.size() != 0) $display("FAIL clr_no_partial: got %0d results required 0", q_acc.size());
        else npass++;
        send(64'd1, 64'd1, 1'b1, st);
        idle();
        wait_n(1, 20, ok);
        nchk++;
        if (!ok || q_acc.size() != 1 || q_acc[0] !== A'(1))
            $display("FAIL clr_result: n=%0d acc=%0d required n=1 acc=1", q_acc.size(), ok ? q_acc[0] : '0);
        else npass++;
    endtask

    task automatic test_async_reset();
        int st;
        bit ok;
        clear_q();
        out_ready = 1'b0;
        send(64'd7, 64'd7, 1'b1, st);
        send(64'd100, 64'd100, 1'b0, st);
        idle();
        @(negedge clk); #1;
        nchk++;
        if (out_valid !== 1'b1 || out_acc !== A'(49))
            $display("FAIL arst_pre: valid=%b acc=%0d required 1/49", out_valid, out_acc);
        else npass++;
        #2;
        rst_n = 1'b0;
        #1;
        nchk++;
        if (out_valid !== 1'b0 || out_acc !== '0)
            $display("FAIL arst_now: valid=%b acc=%0d required 0/0", out_valid, out_acc);
        else npass++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(64'd5, 64'd6, 1'b1, st);
        idle();
        wait_n(1, 20, ok);
        nchk++;
        if (!ok || q_acc.size() != 1 || q_acc[0] !== A'(30))
            $display("FAIL arst_fresh: n=%0d acc=%0d required n=1 acc=30", q_acc.size(), ok ? q_acc[0] : '0);
        else npass++;
    endtask

    initial begin
        logic [A:0] e256, e257;
        // 256*(2^64-1)^2 + 1 = 2^136 - 2^73 + 257: just fits, no overflow.
        e256 = (137'd1 << 136) - (137'd1 << 73) + 137'd257;
        // 257*(2^64-1)^2 + 1 wraps to 2^128 - 257*2^65 + 258.
        e257 = (137'd1 << 128) - (137'd257 << 65) + 137'd258;
        test_reset();
        test_single();
        test_group4();
        test_max(256, e256[A-1:0], 1'b0, e256[A-1:0]);
        test_max(257, e257[A-1:0], 1'b1, '1);
        test_backpressure();
        test_clr();
        test_async_reset();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
